// File: rtl/id_stage_p.sv
// Decode stage: instruction decode, register file with WB bypass, load-use
// stall detection and the ID/EX pipeline register with flush/halt handling.
module id_stage_p #(
  parameter int unsigned DW      = 16,
  parameter int unsigned NREG    = 16,
  parameter int unsigned ZERO_R0 = 0
) (
  input  logic          i_clk,
  input  logic          i_nRst,
  input  logic          i_valid,
  input  logic [15:0]   i_instr,
  input  logic [DW-1:0] i_pc,
  input  logic          i_flush,
  input  logic          i_wrEn,
  input  logic [3:0]    i_wrReg,
  input  logic [DW-1:0] i_wrData,
  output logic          o_stall,
  output logic          o_valid,
  output logic [DW-1:0] o_port0,
  output logic [DW-1:0] o_port1,
  output logic [DW-1:0] o_imm,
  output logic [DW-1:0] o_pc,
  output logic [15:0]   o_instr,
  output logic [3:0]    o_rd,
  output logic [3:0]    o_aluOp,
  output logic          o_memRd,
  output logic          o_memWr,
  output logic          o_regWr,
  output logic          o_aluSrc,
  output logic          o_br,
  output logic          o_jmp,
  output logic          o_hlt
);

  localparam int unsigned AW = 4;
  localparam int unsigned IW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [0:0] {RUN = 1'b0, HALTED = 1'b1} state_t;

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] port0;
    logic [DW-1:0] port1;
    logic [DW-1:0] imm;
    logic [DW-1:0] pc;
    logic [15:0]   instr;
    logic [AW-1:0] rd;
    logic [AW-1:0] aluOp;
    logic          memRd;
    logic          memWr;
    logic          regWr;
    logic          aluSrc;
    logic          br;
    logic          jmp;
    logic          hlt;
  } idEx_t;

  state_t        state, stateNext;
  idEx_t         idEx, idExNext, dec;
  logic [DW-1:0] regFile [NREG];

  logic [AW-1:0] op, rdF, rsF, rtF, rdA0, rdA1;
  logic          use0, use1, wrLegal, hazard;
  logic [DW-1:0] rdVal0, rdVal1;

  // Addresses beyond NREG, and r0 when hardwired, are neither readable nor writable
  function automatic logic addrLegal(input logic [AW-1:0] a);
    return (32'(a) < NREG) && !((ZERO_R0 != 0) && (a == '0));
  endfunction

  assign op      = i_instr[15:12];
  assign rdF     = i_instr[11:8];
  assign rsF     = i_instr[7:4];
  assign rtF     = i_instr[3:0];
  assign wrLegal = i_wrEn && addrLegal(i_wrReg);

  // Opcode decode: which registers are read and the control/immediate payload
  always_comb begin
    dec   = '0;
    rdA0  = rsF;
    rdA1  = rtF;
    use0  = 1'b0;
    use1  = 1'b0;
    dec.instr = i_instr;
    dec.pc    = i_pc;
    dec.rd    = rdF;
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
        use0 = 1'b1;
        use1 = 1'b1;
        dec.aluOp = {1'b0, op[2:0]};
        dec.regWr = 1'b1;
      end
      4'h8: begin
        use0 = 1'b1;
        dec.imm    = {{(DW-4){i_instr[3]}}, i_instr[3:0]};
        dec.aluSrc = 1'b1;
        dec.memRd  = 1'b1;
        dec.regWr  = 1'b1;
      end
      4'h9: begin
        use0 = 1'b1;
        use1 = 1'b1;
        rdA1 = rdF;
        dec.imm    = {{(DW-4){i_instr[3]}}, i_instr[3:0]};
        dec.aluSrc = 1'b1;
        dec.memWr  = 1'b1;
      end
      4'hA: begin
        dec.imm    = {{(DW-8){i_instr[7]}}, i_instr[7:0]};
        dec.aluOp  = 4'h8;
        dec.aluSrc = 1'b1;
        dec.regWr  = 1'b1;
      end
      4'hB: begin
        use1 = 1'b1;
        rdA1 = rdF;
        dec.imm    = {{(DW-8){i_instr[7]}}, i_instr[7:0]};
        dec.aluOp  = 4'h9;
        dec.aluSrc = 1'b1;
        dec.regWr  = 1'b1;
      end
      4'hC: begin
        dec.br  = 1'b1;
        dec.imm = {{(DW-9){i_instr[8]}}, i_instr[8:0]};
      end
      4'hD: begin
        dec.jmp   = 1'b1;
        dec.regWr = 1'b1;
        dec.rd    = 4'(NREG - 1);
        dec.imm   = {{(DW-12){i_instr[11]}}, i_instr[11:0]};
      end
      4'hE: begin
        use0 = 1'b1;
        dec.jmp = 1'b1;
      end
      default: dec.hlt = 1'b1;
    endcase
    dec.port0 = use0 ? rdVal0 : '0;
    dec.port1 = use1 ? rdVal1 : '0;
  end

  // Register read with write-through from the WB port
  always_comb begin
    rdVal0 = '0;
    rdVal1 = '0;
    if (addrLegal(rdA0))
      rdVal0 = (wrLegal && (rdA0 == i_wrReg)) ? i_wrData : regFile[IW'(rdA0)];
    if (addrLegal(rdA1))
      rdVal1 = (wrLegal && (rdA1 == i_wrReg)) ? i_wrData : regFile[IW'(rdA1)];
  end

  always_comb begin
    hazard = 1'b0;
    if (use0 && (rdA0 == idEx.rd) && !((ZERO_R0 != 0) && (rdA0 == '0)))
      hazard = 1'b1;
    if (use1 && (rdA1 == idEx.rd) && !((ZERO_R0 != 0) && (rdA1 == '0)))
      hazard = 1'b1;
  end

  assign o_stall = (state == RUN) && idEx.valid && idEx.memRd && i_valid && !i_flush && hazard;

  // Next state and ID/EX contents: flush > halted > stall > load
  always_comb begin
    stateNext = state;
    idExNext  = '0;
    if (i_flush) begin
      idExNext = '0;
    end else if (state == HALTED) begin
      idExNext = '0;
    end else if (o_stall) begin
      idExNext = '0;
    end else if (i_valid) begin
      idExNext       = dec;
      idExNext.valid = 1'b1;
      if (dec.hlt)
        stateNext = HALTED;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_nRst) begin
      state <= RUN;
      idEx  <= '0;
    end else begin
      state <= stateNext;
      idEx  <= idExNext;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_nRst) begin
      for (int i = 0; i < int'(NREG); i++)
        regFile[i] <= '0;
    end else if (wrLegal) begin
      regFile[IW'(i_wrReg)] <= i_wrData;
    end
  end

  assign o_valid  = idEx.valid;
  assign o_port0  = idEx.port0;
  assign o_port1  = idEx.port1;
  assign o_imm    = idEx.imm;
  assign o_pc     = idEx.pc;
  assign o_instr  = idEx.instr;
  assign o_rd     = idEx.rd;
  assign o_aluOp  = idEx.aluOp;
  assign o_memRd  = idEx.memRd;
  assign o_memWr  = idEx.memWr;
  assign o_regWr  = idEx.regWr;
  assign o_aluSrc = idEx.aluSrc;
  assign o_br     = idEx.br;
  assign o_jmp    = idEx.jmp;
  assign o_hlt    = idEx.hlt;

endmodule

// File: tb/tb_id_stage_p.sv
// Scoreboard bench for id_stage_p: default build plus a DW=32/NREG=8/ZERO_R0=1 build.
module tb_id_stage_p;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  localparam logic [6:0] CMR = 7'b1000000, CMW = 7'b0100000, CRW = 7'b0010000,
                         CAS = 7'b0001000, CBR = 7'b0000100, CJ = 7'b0000010,
                         CH = 7'b0000001;

  typedef struct {
    logic [31:0] pc, p0, p1, imm;
    logic [15:0] ins;
    logic [3:0]  rd, alu;
    logic [6:0]  ctl;
  } exp_t;

  exp_t qA[$];
  exp_t qB[$];

  // default build
  logic aN, aV, aFl, aWe;
  logic [15:0] aIns, aPc, aWd;
  logic [3:0] aWr;
  logic aStall, aOV, aMr, aMw, aRw, aAs, aBr, aJ, aH;
  logic [15:0] aP0, aP1, aImm, aOPc, aOIns;
  logic [3:0] aRd, aAlu;

  // wide build
  logic bN, bV, bFl, bWe;
  logic [15:0] bIns;
  logic [31:0] bPc, bWd;
  logic [3:0] bWr;
  logic bStall, bOV, bMr, bMw, bRw, bAs, bBr, bJ, bH;
  logic [31:0] bP0, bP1, bImm, bOPc;
  logic [15:0] bOIns;
  logic [3:0] bRd, bAlu;

  id_stage_p dutA (
    .i_clk(clk), .i_nRst(aN), .i_valid(aV), .i_instr(aIns), .i_pc(aPc),
    .i_flush(aFl), .i_wrEn(aWe), .i_wrReg(aWr), .i_wrData(aWd),
    .o_stall(aStall), .o_valid(aOV), .o_port0(aP0), .o_port1(aP1), .o_imm(aImm),
    .o_pc(aOPc), .o_instr(aOIns), .o_rd(aRd), .o_aluOp(aAlu),
    .o_memRd(aMr), .o_memWr(aMw), .o_regWr(aRw), .o_aluSrc(aAs),
    .o_br(aBr), .o_jmp(aJ), .o_hlt(aH)
  );

  id_stage_p #(.DW(32), .NREG(8), .ZERO_R0(1)) dutB (
    .i_clk(clk), .i_nRst(bN), .i_valid(bV), .i_instr(bIns), .i_pc(bPc),
    .i_flush(bFl), .i_wrEn(bWe), .i_wrReg(bWr), .i_wrData(bWd),
    .o_stall(bStall), .o_valid(bOV), .o_port0(bP0), .o_port1(bP1), .o_imm(bImm),
    .o_pc(bOPc), .o_instr(bOIns), .o_rd(bRd), .o_aluOp(bAlu),
    .o_memRd(bMr), .o_memWr(bMw), .o_regWr(bRw), .o_aluSrc(bAs),
    .o_br(bBr), .o_jmp(bJ), .o_hlt(bH)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [15:0] ins,
                              input logic [31:0] p0, p1, imm, input logic [3:0] rd, alu,
                              input logic [6:0] ctl);
    exp_t e;
    e.pc = pc; e.ins = ins; e.p0 = p0; e.p1 = p1; e.imm = imm;
    e.rd = rd; e.alu = alu; e.ctl = ctl;
    return e;
  endfunction

  task automatic cmpRec(input string p, input logic [31:0] pc, input logic [15:0] ins,
                        input logic [31:0] p0, p1, imm, input logic [3:0] rd, alu,
                        input logic [6:0] ctl, input exp_t e);
    check({p, "_pc"}, pc, e.pc);
    check({p, "_instr"}, 32'(ins), 32'(e.ins));
    check({p, "_port0"}, p0, e.p0);
    check({p, "_port1"}, p1, e.p1);
    check({p, "_imm"}, imm, e.imm);
    check({p, "_rd"}, 32'(rd), 32'(e.rd));
    check({p, "_aluOp"}, 32'(alu), 32'(e.alu));
    check({p, "_ctl"}, 32'(ctl), 32'(e.ctl));
  endtask

  task automatic bubble(input string p, input logic v, input logic [6:0] ctl,
                        input logic [31:0] dataOr);
    check({p, "_bub_valid"}, 32'(v), 32'd0);
    check({p, "_bub_ctl"}, 32'(ctl), 32'd0);
    check({p, "_bub_data"}, dataOr, 32'd0);
  endtask

  // Monitors: every valid ID/EX output must match the oldest expectation
  always @(negedge clk) begin : monA
    exp_t e;
    if (aOV === 1'b1) begin
      if (qA.size() == 0) begin
        checks++; failures++;
        $display("FAIL A_unexpected: got valid instr %h expected none", aOIns);
      end else begin
        e = qA.pop_front();
        cmpRec("A", 32'(aOPc), aOIns, 32'(aP0), 32'(aP1), 32'(aImm), aRd, aAlu,
               {aMr, aMw, aRw, aAs, aBr, aJ, aH}, e);
      end
    end
  end

  always @(negedge clk) begin : monB
    exp_t e;
    if (bOV === 1'b1) begin
      if (qB.size() == 0) begin
        checks++; failures++;
        $display("FAIL B_unexpected: got valid instr %h expected none", bOIns);
      end else begin
        e = qB.pop_front();
        cmpRec("B", bOPc, bOIns, bP0, bP1, bImm, bRd, bAlu,
               {bMr, bMw, bRw, bAs, bBr, bJ, bH}, e);
      end
    end
  end

  task automatic bubA();
    bubble("A", aOV, {aMr, aMw, aRw, aAs, aBr, aJ, aH},
           32'(aP0 | aP1 | aImm | aOPc | aOIns) | 32'({aRd, aAlu}));
  endtask

  task automatic bubB();
    bubble("B", bOV, {bMr, bMw, bRw, bAs, bBr, bJ, bH},
           bP0 | bP1 | bImm | bOPc | 32'(bOIns) | 32'({bRd, bAlu}));
  endtask

  task automatic stepA(input logic v, input logic [15:0] ins, pc, input logic fl, we,
                       input logic [3:0] wr, input logic [15:0] wd, input logic st, bub);
    @(posedge clk); #1;
    aV = v; aIns = ins; aPc = pc; aFl = fl; aWe = we; aWr = wr; aWd = wd;
    #1;
    check("A_stall", 32'(aStall), 32'(st));
    if (bub) bubA();
  endtask

  task automatic stepB(input logic v, input logic [15:0] ins, input logic [31:0] pc,
                       input logic fl, we, input logic [3:0] wr, input logic [31:0] wd,
                       input logic st, bub);
    @(posedge clk); #1;
    bV = v; bIns = ins; bPc = pc; bFl = fl; bWe = we; bWr = wr; bWd = wd;
    #1;
    check("B_stall", 32'(bStall), 32'(st));
    if (bub) bubB();
  endtask

  initial begin
    aN = 0; aV = 0; aFl = 0; aWe = 0; aIns = '0; aPc = '0; aWd = '0; aWr = '0;
    bN = 0; bV = 0; bFl = 0; bWe = 0; bIns = '0; bPc = '0; bWd = '0; bWr = '0;
    repeat (2) @(posedge clk);
    #1;
    bubA();
    bubB();
    aN = 1; bN = 1;

    // Default build: bypass, ALU/memory/branch decode, load-use, flush, halt
    stepA(0, 16'h0000, 16'h0000, 0, 1, 4'd3, 16'h1234, 0, 0);
    stepA(1, 16'h0133, 16'h0010, 0, 0, 4'd0, 16'h0000, 0, 0);
    qA.push_back(mk(32'h10, 16'h0133, 32'h1234, 32'h1234, 0, 4'd1, 4'd0, CRW));
    stepA(1, 16'h1250, 16'h0011, 0, 1, 4'd5, 16'hBEEF, 0, 0);
    qA.push_back(mk(32'h11, 16'h1250, 32'hBEEF, 0, 0, 4'd2, 4'd1, CRW));
    stepA(0, 16'h0000, 16'h0000, 0, 1, 4'd0, 16'h0007, 0, 0);
    stepA(1, 16'h0703, 16'h0012, 0, 0, 4'd0, 16'h0000, 0, 0);
    qA.push_back(mk(32'h12, 16'h0703, 32'h7, 32'h1234, 0, 4'd7, 4'd0, CRW));
    stepA(1, 16'h841F, 16'h0013, 0, 1, 4'd2, 16'h00A5, 0, 0);
    qA.push_back(mk(32'h13, 16'h841F, 0, 0, 32'hFFFF, 4'd4, 4'd0, CMR | CAS | CRW));
    stepA(1, 16'h0642, 16'h0014, 0, 0, 4'd0, 16'h0000, 1, 0);
    stepA(1, 16'h0642, 16'h0014, 0, 0, 4'd0, 16'h0000, 0, 1);
    qA.push_back(mk(32'h14, 16'h0642, 0, 32'hA5, 0, 4'd6, 4'd0, CRW));
    stepA(1, 16'h8411, 16'h0015, 0, 0, 4'd0, 16'h0000, 0, 0);
    qA.push_back(mk(32'h15, 16'h8411, 0, 0, 32'h1, 4'd4, 4'd0, CMR | CAS | CRW));
    stepA(1, 16'hA448, 16'h0016, 0, 0, 4'd0, 16'h0000, 0, 0);
    qA.push_back(mk(32'h16, 16'hA448, 0, 0, 32'h48, 4'd4, 4'd8, CAS | CRW));
    stepA(1, 16'hD123, 16'h0020, 1, 0, 4'd0, 16'h0000, 0, 0);
    check("A_flush_keeps_ex", 32'(aOV), 32'd1);
    stepA(1, 16'hC7FE, 16'h0021, 0, 0, 4'd0, 16'h0000, 0, 1);
    qA.push_back(mk(32'h21, 16'hC7FE, 0, 0, 32'hFFFE, 4'd7, 4'd0, CBR));
    stepA(1, 16'h8411, 16'h0022, 0, 0, 4'd0, 16'h0000, 0, 0);
    qA.push_back(mk(32'h22, 16'h8411, 0, 0, 32'h1, 4'd4, 4'd0, CMR | CAS | CRW));
    stepA(1, 16'h0642, 16'h0023, 1, 0, 4'd0, 16'h0000, 0, 0);
    check("A_flush_keeps_lw", 32'(aOV), 32'd1);
    stepA(1, 16'hD800, 16'h0024, 0, 0, 4'd0, 16'h0000, 0, 1);
    qA.push_back(mk(32'h24, 16'hD800, 0, 0, 32'hF800, 4'd15, 4'd0, CJ | CRW));
    stepA(1, 16'hE030, 16'h0025, 0, 0, 4'd0, 16'h0000, 0, 0);
    qA.push_back(mk(32'h25, 16'hE030, 32'h1234, 0, 0, 4'd0, 4'd0, CJ));
    stepA(1, 16'h9532, 16'h0026, 0, 0, 4'd0, 16'h0000, 0, 0);
    qA.push_back(mk(32'h26, 16'h9532, 32'h1234, 32'hBEEF, 32'h2, 4'd5, 4'd0, CMW | CAS));
    stepA(1, 16'hB29C, 16'h0027, 0, 0, 4'd0, 16'h0000, 0, 0);
    qA.push_back(mk(32'h27, 16'hB29C, 0, 32'hA5, 32'hFF9C, 4'd2, 4'd9, CAS | CRW));
    stepA(1, 16'h7123, 16'h0028, 0, 0, 4'd0, 16'h0000, 0, 0);
    qA.push_back(mk(32'h28, 16'h7123, 32'hA5, 32'h1234, 0, 4'd1, 4'd7, CRW));
    stepA(1, 16'hF000, 16'h0030, 0, 0, 4'd0, 16'h0000, 0, 0);
    qA.push_back(mk(32'h30, 16'hF000, 0, 0, 0, 4'd0, 4'd0, CH));
    for (int i = 0; i < 11; i++)
      stepA(1, 16'h0133, 16'h0031, 0, 0, 4'd0, 16'h0000, 0, (i != 0));
    aN = 0;
    stepA(1, 16'h0133, 16'h0040, 0, 0, 4'd0, 16'h0000, 0, 1);
    aN = 1;
    qA.push_back(mk(32'h40, 16'h0133, 0, 0, 0, 4'd1, 4'd0, CRW));
    stepA(0, 16'h0000, 16'h0000, 0, 0, 4'd0, 16'h0000, 0, 0);
    stepA(0, 16'h0000, 16'h0000, 0, 0, 4'd0, 16'h0000, 0, 0);

    // Wide build: hardwired r0, out-of-range registers, 32-bit immediates
    stepB(0, 16'h0000, 32'h0, 0, 1, 4'd0, 32'h7, 0, 0);
    stepB(1, 16'h0100, 32'h100, 0, 1, 4'd0, 32'h9, 0, 0);
    qB.push_back(mk(32'h100, 16'h0100, 0, 0, 0, 4'd1, 4'd0, CRW));
    stepB(1, 16'hA280, 32'h101, 0, 0, 4'd0, 32'h0, 0, 0);
    qB.push_back(mk(32'h101, 16'hA280, 0, 0, 32'hFFFFFF80, 4'd2, 4'd8, CAS | CRW));
    stepB(0, 16'h0000, 32'h0, 0, 1, 4'd12, 32'h55, 0, 0);
    stepB(1, 16'h01CC, 32'h102, 0, 1, 4'd12, 32'h66, 0, 0);
    qB.push_back(mk(32'h102, 16'h01CC, 0, 0, 0, 4'd1, 4'd0, CRW));
    stepB(1, 16'hD005, 32'h103, 0, 0, 4'd0, 32'h0, 0, 0);
    qB.push_back(mk(32'h103, 16'hD005, 0, 0, 32'h5, 4'd7, 4'd0, CJ | CRW));
    stepB(1, 16'h8010, 32'h104, 0, 1, 4'd6, 32'hDEADBEEF, 0, 0);
    qB.push_back(mk(32'h104, 16'h8010, 0, 0, 0, 4'd0, 4'd0, CMR | CAS | CRW));
    stepB(1, 16'h0360, 32'h105, 0, 0, 4'd0, 32'h0, 0, 0);
    qB.push_back(mk(32'h105, 16'h0360, 32'hDEADBEEF, 0, 0, 4'd3, 4'd0, CRW));
    stepB(1, 16'h8561, 32'h106, 0, 0, 4'd0, 32'h0, 0, 0);
    qB.push_back(mk(32'h106, 16'h8561, 32'hDEADBEEF, 0, 32'h1, 4'd5, 4'd0, CMR | CAS | CRW));
    stepB(1, 16'h1056, 32'h107, 0, 0, 4'd0, 32'h0, 1, 0);
    stepB(1, 16'h1056, 32'h107, 0, 0, 4'd0, 32'h0, 0, 1);
    qB.push_back(mk(32'h107, 16'h1056, 0, 32'hDEADBEEF, 0, 4'd0, 4'd1, CRW));
    stepB(0, 16'h0000, 32'h0, 0, 0, 4'd0, 32'h0, 0, 0);
    stepB(0, 16'h0000, 32'h0, 0, 0, 4'd0, 32'h0, 0, 0);

    @(posedge clk); #1;
    check("A_pending", 32'(qA.size()), 32'd0);
    check("B_pending", 32'(qB.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_stage_p.md
# id_stage_p

Parametrised decode stage for the 16-bit-instruction pipelined CPU: decodes the IF/ID instruction, reads the register file (with write-through bypass from WB), detects load-use hazards and registers all decoded fields into an ID/EX pipeline register with valid, stall, flush and halt handling. It sits between the IF/ID register and the EX stage. It generalises the earlier single-width decode stage with configurable data width, register count and r0 behaviour.

## Interface
- DW, 16, datapath/register width; must be >= 16
- NREG, 16, number of registers, 2..16; register addresses >= NREG read 0 and ignore writes
- ZERO_R0, 0, 1 = r0 reads 0 and ignores writes
- i_clk  in  1  clock; all state updates on rising edge
- i_nRst  in  1  reset, synchronous, active-low
- i_valid  in  1  i_instr/i_pc hold a real instruction
- i_instr  in  16  instruction from IF/ID
- i_pc  in  DW  PC+1 of i_instr
- i_flush  in  1  EX redirect (taken branch/jump); kill the instruction in ID
- i_wrEn, i_wrReg[3:0], i_wrData[DW]  in  WB write port
- o_stall  out  1  combinational; IF/ID must hold its contents this cycle
- o_valid  out  1  ID/EX holds a real instruction
- o_port0, o_port1  out  DW  registered operand values
- o_imm  out  DW  registered sign-extended immediate
- o_pc  out  DW; o_instr  out  16; o_rd  out  4; o_aluOp  out  4
- o_memRd, o_memWr, o_regWr, o_aluSrc, o_br, o_jmp, o_hlt  out  1 each

## Operation
- Fields: op=[15:12], rd=[11:8], rs=[7:4], rt=[3:0].
- op 0x0-0x7 ALU: port0=rs, port1=rt, aluOp={0,op[2:0]}, regWr.
- 0x8 LW: port0=rs, imm=sext(i_instr[3:0]), aluOp=0, aluSrc, memRd, regWr.
- 0x9 SW: port0=rs, port1=rd, imm=sext([3:0]), aluOp=0, aluSrc, memWr.
- 0xA LLB: imm=sext([7:0]), aluOp=8, aluSrc, regWr. 0xB LHB: port1=rd, imm=sext([7:0]), aluOp=9, aluSrc, regWr.
- 0xC B: br, imm=sext([8:0]); condition carried in o_instr[11:9].
- 0xD JAL: jmp, regWr, o_rd=NREG-1, imm=sext([11:0]). 0xE JR: jmp, port0=rs. 0xF HLT: hlt.
- Unused read ports output 0; sources read per opcode only count for hazards.
- Register file: NREG x DW, written at posedge when i_wrEn and address legal (and not r0 when ZERO_R0).
- Bypass: read address == i_wrReg with a legal write in the same cycle returns i_wrData.
- Load-use: o_stall=1 when o_valid & o_memRd & i_valid & !i_flush & state RUN and o_rd equals a register the current opcode reads (r0 excluded when ZERO_R0). On stall ID/EX loads a bubble.
- Bubble = o_valid=0 and all control outputs 0; data outputs don't-care but held at 0.
- States: RUN, HALTED. RUN->HALTED when a valid, unflushed, unstalled HLT is loaded into ID/EX. HALTED: i_valid ignored, bubbles only, o_stall=0; left only by reset.
- Priority: reset > flush > halted > stall > load.

## Timing
- Decode, read and bypass combinational; ID/EX updates every posedge: 1-cycle latency i_instr -> outputs.
- o_stall asserted in the same cycle as the hazard; exactly one bubble per load-use pair.
- i_flush: the instruction currently in ID is discarded (bubble next cycle), o_stall forced 0; o_valid of the already-issued EX instruction is unaffected.
- Reset (any cycle, including mid-stall or HALTED): all registers and every output 0, state RUN, takes effect at the sampling edge.
- A write and read of the same register in the same cycle never returns stale data.

## Test plan
- Reset, then WB write r3=0x1234, next cycle ADD r1,r3,r3 -> o_port0=o_port1=0x1234, o_aluOp=0, o_regWr=1, o_valid=1 one cycle later.
- Same-cycle WB write r5=0xBEEF with SUB r2,r5,r0 in ID -> o_port0=0xBEEF; with ZERO_R0=1 write r0=7 then read r0 -> 0.
- LW r4,[r1+0xF] then ADD r6,r4,r2 -> o_imm=0xFFFF, o_stall=1 for one cycle, one bubble, ADD issues next cycle; LW then LLB r4 -> no stall.
- i_flush asserted with JAL in ID -> next cycle o_valid=0, o_jmp=0; following instruction issues normally.
- HLT issued -> o_hlt=1 one cycle, then o_valid stays 0 with i_valid=1 for 10 cycles; i_nRst=0 -> RUN, outputs 0.
- DW=32, NREG=8: LLB r2,0x80 -> o_imm=0xFFFFFF80; write/read r12 -> reads 0; JAL -> o_rd=7.
